// File: rtl/risc_core_param.sv
// Multi-cycle parameterised RISC core: FETCH/DECODE/EXEC/MEM/HALT over a single req/rdy memory port.
// Define RISC_CORE_IRQ_EN to add a level interrupt input with RETI (opcode E) support.
module risc_core_param #(
   parameter int unsigned   DW       = 16,
   parameter int unsigned   RW       = 3,
   parameter logic [DW-1:0] RESET_PC = '0,
   parameter logic [DW-1:0] IRQ_VEC  = DW'(16'h0010)
) (
   input  logic          clk,
   input  logic          reset,
`ifdef RISC_CORE_IRQ_EN
   input  logic          irq,
`endif
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] Address,
   output logic [DW-1:0] D_out,
   input  logic [DW-1:0] D_in,
   input  logic          mem_rdy,
   output logic [7:0]    Status
);

   localparam int unsigned   NumRegs = 2 ** RW;
   localparam logic [DW-1:0] One     = 1;

   localparam logic [3:0] OpAdd  = 4'h1;
   localparam logic [3:0] OpSub  = 4'h2;
   localparam logic [3:0] OpAnd  = 4'h3;
   localparam logic [3:0] OpOr   = 4'h4;
   localparam logic [3:0] OpXor  = 4'h5;
   localparam logic [3:0] OpInc  = 4'h6;
   localparam logic [3:0] OpLd   = 4'h7;
   localparam logic [3:0] OpSt   = 4'h8;
   localparam logic [3:0] OpLdi  = 4'h9;
   localparam logic [3:0] OpJmp  = 4'hA;
   localparam logic [3:0] OpJz   = 4'hB;
   localparam logic [3:0] OpJn   = 4'hC;
   localparam logic [3:0] OpJc   = 4'hD;
`ifdef RISC_CORE_IRQ_EN
   localparam logic [3:0] OpReti = 4'hE;
`endif
   localparam logic [3:0] OpHalt = 4'hF;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StHalt   = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] pc_q, pc_d;
   logic [DW-1:0] ir_q, ir_d;
   logic [DW-1:0] a_q, a_d;
   logic [DW-1:0] b_q, b_d;
   logic          c_q, c_d, n_q, n_d, z_q, z_d;
   logic          req_q, req_d, we_q, we_d;
   logic [DW-1:0] addr_q, addr_d;
   logic [DW-1:0] dout_q, dout_d;
   logic [DW-1:0] rf_q [NumRegs];
`ifdef RISC_CORE_IRQ_EN
   logic [DW-1:0] epc_q, epc_d;
   logic          in_isr_q, in_isr_d;
`endif

   logic          rf_we;
   logic [RW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [DW:0]   alu;
   logic          alu_op;
   logic          start_fetch;

   logic [3:0]    op_f;
   logic [RW-1:0] w_f, r_f, s_f;

   assign op_f = ir_q[DW-1:DW-4];
   assign w_f  = ir_q[3*RW-1:2*RW];
   assign r_f  = ir_q[2*RW-1:RW];
   assign s_f  = ir_q[RW-1:0];

   if (DW > 4 + 3 * RW) begin : g_pad
      logic unused_ir;
      assign unused_ir = ^ir_q[DW-5:3*RW];
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      n_d         = n_q;
      z_d         = z_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      rf_we       = 1'b0;
      rf_waddr    = w_f;
      rf_wdata    = '0;
      alu         = '0;
      alu_op      = 1'b0;
      start_fetch = 1'b0;
`ifdef RISC_CORE_IRQ_EN
      epc_d       = epc_q;
      in_isr_d    = in_isr_q;
`endif
      unique case (state_q)
         StFetch: begin
            // Right after reset no request is outstanding yet; issue it now.
            if (!req_q) begin
               start_fetch = 1'b1;
            end else if (mem_rdy) begin
               ir_d    = D_in;
               pc_d    = pc_q + One;
               req_d   = 1'b0;
               state_d = StDecode;
            end
         end
         StDecode: begin
            a_d     = rf_q[r_f];
            b_d     = rf_q[s_f];
            state_d = StExec;
         end
         StExec: begin
            start_fetch = 1'b1;
            case (op_f)
               OpAdd: begin alu = {1'b0, a_q} + {1'b0, b_q}; alu_op = 1'b1; end
               OpSub: begin alu = {1'b0, a_q} - {1'b0, b_q}; alu_op = 1'b1; end
               OpAnd: begin alu = {1'b0, a_q & b_q}; alu_op = 1'b1; end
               OpOr:  begin alu = {1'b0, a_q | b_q}; alu_op = 1'b1; end
               OpXor: begin alu = {1'b0, a_q ^ b_q}; alu_op = 1'b1; end
               OpInc: begin alu = {1'b0, a_q} + {{DW{1'b0}}, 1'b1}; alu_op = 1'b1; end
               OpLd, OpSt, OpLdi: begin
                  start_fetch = 1'b0;
                  state_d     = StMem;
                  req_d       = 1'b1;
                  we_d        = (op_f == OpSt);
                  addr_d      = (op_f == OpLdi) ? pc_q : a_q;
                  if (op_f == OpSt) dout_d = b_q;
               end
               OpJmp: pc_d = a_q;
               OpJz:  if (z_q) pc_d = a_q;
               OpJn:  if (n_q) pc_d = a_q;
               OpJc:  if (c_q) pc_d = a_q;
`ifdef RISC_CORE_IRQ_EN
               OpReti: begin
                  pc_d     = epc_q;
                  in_isr_d = 1'b0;
               end
`endif
               OpHalt: begin
                  start_fetch = 1'b0;
                  state_d     = StHalt;
               end
               default: ;
            endcase
            if (alu_op) begin
               rf_we    = 1'b1;
               rf_wdata = alu[DW-1:0];
               c_d      = alu[DW];
               n_d      = alu[DW-1];
               z_d      = (alu[DW-1:0] == '0);
            end
         end
         StMem: begin
            if (mem_rdy) begin
               req_d       = 1'b0;
               we_d        = 1'b0;
               start_fetch = 1'b1;
               if (op_f != OpSt) begin
                  rf_we    = 1'b1;
                  rf_wdata = D_in;
               end
               if (op_f == OpLdi) pc_d = pc_q + One;
            end
         end
         StHalt: ;
         default: state_d = StHalt;
      endcase

      if (start_fetch) begin
         state_d = StFetch;
         req_d   = 1'b1;
         we_d    = 1'b0;
         addr_d  = pc_d;
`ifdef RISC_CORE_IRQ_EN
         if (irq && !in_isr_q) begin
            epc_d    = pc_d;
            pc_d     = IRQ_VEC;
            in_isr_d = 1'b1;
            addr_d   = IRQ_VEC;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= RESET_PC;
         dout_q  <= '0;
         for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
`ifdef RISC_CORE_IRQ_EN
         epc_q    <= '0;
         in_isr_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         n_q     <= n_d;
         z_q     <= z_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         if (rf_we) rf_q[rf_waddr] <= rf_wdata;
`ifdef RISC_CORE_IRQ_EN
         epc_q    <= epc_d;
         in_isr_q <= in_isr_d;
`endif
      end
   end

   assign mem_req = req_q;
   assign mem_we  = we_q;
   assign Address = addr_q;
   assign D_out   = dout_q;
   assign Status  = {state_q == StHalt, state_q, 1'b0, c_q, n_q, z_q};

endmodule

// File: tb/tb_risc_core_param.sv
// Directed self-checking bench for risc_core_param (DW=16, RW=3) with a simple memory model.
module tb_risc_core_param;

   logic        clk;
   logic        reset;
`ifdef RISC_CORE_IRQ_EN
   logic        irq;
`endif
   logic        mem_req;
   logic        mem_we;
   logic [15:0] addr;
   logic [15:0] d_out;
   logic [15:0] d_in;
   logic        mem_rdy;
   logic [7:0]  status;

   logic [15:0] mem [256];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wr_count = 0;
   logic [15:0] last_wr_addr = '0;
   logic [15:0] last_wr_data = '0;

   risc_core_param dut (
      .clk     (clk),
      .reset   (reset),
`ifdef RISC_CORE_IRQ_EN
      .irq     (irq),
`endif
      .mem_req (mem_req),
      .mem_we  (mem_we),
      .Address (addr),
      .D_out   (d_out),
      .D_in    (d_in),
      .mem_rdy (mem_rdy),
      .Status  (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign d_in = mem[addr[7:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset && mem_req && mem_we && mem_rdy) begin
         wr_count     <= wr_count + 1;
         last_wr_addr <= addr;
         last_wr_data <= d_out;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] w,
                                       input logic [2:0] r, input logic [2:0] s);
      return {op, 3'b000, w, r, s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for an instruction fetch at address a; returns the cycle it was seen.
   task automatic wait_fetch(input logic [15:0] a, input string tag, output int when);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1 && mem_we === 1'b0 && addr === a) found = 1'b1;
      end
      when = cyc;
      chk(tag, {31'd0, found}, 32'd1);
   endtask

   int  t0, t1;
   bit  seen;
   int  nreq;

   initial begin
      reset   = 1'b0;
      mem_rdy = 1'b1;
`ifdef RISC_CORE_IRQ_EN
      irq     = 1'b0;
`endif
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0]     = enc(4'h9, 3'd1, 3'd0, 3'd0);  // LDI R1
      mem[1]     = 16'h0005;
      mem[2]     = enc(4'h9, 3'd2, 3'd0, 3'd0);  // LDI R2
      mem[3]     = 16'h0007;
      mem[4]     = enc(4'h1, 3'd3, 3'd1, 3'd2);  // ADD R3=R1+R2
      mem[5]     = enc(4'h9, 3'd5, 3'd0, 3'd0);  // LDI R5
      mem[6]     = 16'h0080;
      mem[7]     = enc(4'h8, 3'd0, 3'd5, 3'd3);  // ST M[R5]=R3
      mem[8]     = enc(4'h9, 3'd1, 3'd0, 3'd0);  // LDI R1
      mem[9]     = 16'hFFFF;
      mem[10]    = enc(4'h6, 3'd2, 3'd1, 3'd0);  // INC R2=R1
      mem[11]    = enc(4'h8, 3'd0, 3'd5, 3'd2);  // ST M[R5]=R2
      mem[12]    = enc(4'h9, 3'd1, 3'd0, 3'd0);  // LDI R1
      mem[13]    = 16'h0003;
      mem[14]    = enc(4'h9, 3'd2, 3'd0, 3'd0);  // LDI R2
      mem[15]    = 16'h0005;
      mem[16]    = enc(4'h2, 3'd3, 3'd1, 3'd2);  // SUB R3=R1-R2
      mem[17]    = enc(4'h9, 3'd4, 3'd0, 3'd0);  // LDI R4
      mem[18]    = 16'h0040;
      mem[19]    = enc(4'hD, 3'd0, 3'd4, 3'd0);  // JC R4
      mem[8'h40] = enc(4'hB, 3'd0, 3'd4, 3'd0);  // JZ R4 (not taken)
      mem[8'h41] = enc(4'h7, 3'd6, 3'd5, 3'd0);  // LD R6=M[R5]

      #12;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_addr", {16'd0, addr}, 32'h0000);
      chk("rst_dout", {16'd0, d_out}, 32'h0000);
      chk("rst_status", {24'd0, status}, 32'h00);
      @(negedge clk);
      reset = 1'b1;

      wait_fetch(16'd0, "fetch_0", t0);
      wait_fetch(16'd2, "fetch_2", t0);
      wait_fetch(16'd4, "fetch_4", t1);
      chk("ldi_latency", t1 - t0, 32'd4);
      wait_fetch(16'd5, "fetch_5", t0);
      chk("add_latency", t0 - t1, 32'd3);
      chk("add_flags", {24'd0, status}, 32'h00);

      // Store with mem_rdy held low for four edges.
      wait_fetch(16'd7, "fetch_st", t0);
      @(posedge clk);
      #1 mem_rdy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1 && mem_we === 1'b1) seen = 1'b1;
      end
      chk("st_issue", {31'd0, seen}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("st_stable", {mem_req, mem_we, addr, d_out}, {2'b11, 16'h0080, 16'd12});
      end
      mem_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("st_count", wr_count, 32'd1);
      chk("st_data", {last_wr_addr, last_wr_data}, {16'h0080, 16'd12});

      wait_fetch(16'd11, "fetch_11", t0);
      chk("inc_flags", {24'd0, status}, 32'h05);
      wait_fetch(16'd12, "fetch_12", t0);
      chk("st2_write", {wr_count[15:0], last_wr_data}, {16'd2, 16'h0000});
      chk("st_keeps_flags", {24'd0, status}, 32'h05);

      wait_fetch(16'd17, "fetch_17", t0);
      chk("sub_flags", {24'd0, status}, 32'h06);
      wait_fetch(16'd19, "fetch_jc", t0);
      wait_fetch(16'h0040, "jc_taken", t1);
      chk("jc_latency", t1 - t0, 32'd3);
      wait_fetch(16'h0041, "jz_not_taken", t0);
      chk("jz_latency", t0 - t1, 32'd3);

      // Reset in the middle of a stalled load.
      @(posedge clk);
      #1 mem_rdy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1 && mem_we === 1'b0 && addr === 16'h0080) seen = 1'b1;
      end
      chk("ld_issue", {31'd0, seen}, 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("ld_rst_req", {31'd0, mem_req}, 32'd0);
      chk("ld_rst_addr", {16'd0, addr}, 32'h0000);
      chk("ld_rst_status", {24'd0, status}, 32'h00);
      mem[0]  = enc(4'h8, 3'd0, 3'd5, 3'd3);  // ST M[R5]=R3, both zero after reset
      mem[1]  = enc(4'hF, 3'd0, 3'd0, 3'd0);  // HALT
      mem_rdy = 1'b1;
      @(negedge clk);
      reset = 1'b1;

      wait_fetch(16'd0, "refetch_0", t0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (wr_count == 3) seen = 1'b1;
      end
      chk("regs_zero_wr", {31'd0, seen}, 32'd1);
      chk("regs_zero_val", {last_wr_addr, last_wr_data}, 32'h0000_0000);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (status[7] === 1'b1) seen = 1'b1;
      end
      chk("halt_reached", {31'd0, seen}, 32'd1);
      chk("halt_status", {24'd0, status}, 32'hC0);
      nreq = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (mem_req !== 1'b0) nreq++;
      end
      chk("halt_quiet", nreq, 32'd0);

`ifdef RISC_CORE_IRQ_EN
      reset = 1'b0;
      mem[0]     = 16'h0000;
      mem[1]     = 16'h0000;
      mem[2]     = 16'h0000;
      mem[3]     = enc(4'hF, 3'd0, 3'd0, 3'd0);
      mem[8'h10] = enc(4'hE, 3'd0, 3'd0, 3'd0);  // RETI
      @(negedge clk);
      reset = 1'b1;
      wait_fetch(16'd2, "irq_fetch_2", t0);
      irq = 1'b1;
      wait_fetch(16'h0010, "irq_vector", t0);
      irq = 1'b0;
      wait_fetch(16'h0003, "reti_resume", t0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
